// File: rtl/ram_message_streamer.sv
// Streams a NUL-terminated byte message from a synchronous-read RAM to a
// UART transmitter with a valid/ready handshake. The message ends at the
// first NUL byte or after the last RAM location. There is no wrap-around.
module ram_message_streamer #(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned AddressBits = 7,
    parameter int unsigned MemorySize  = 100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AddressBits:0]   startAddress,
    output logic                   writeOrread,
    output logic [AddressBits:0]   address,
    input  logic [DataWidth-1:0]   dout,
    output logic [DataWidth-1:0]   txData,
    output logic                   txValid,
    input  logic                   txReady,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             byteCount
);

    localparam int unsigned AddrWidth = AddressBits + 1;
    localparam logic [AddressBits:0] LastAddress = AddrWidth'(MemorySize - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        SEND,
        FINISH
    } state_t;

    state_t state;

    // Message sequencer: fetch a byte, stop on NUL, otherwise hand it to the transmitter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            address     <= '0;
            txData      <= '0;
            txValid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            byteCount   <= 8'd0;
            writeOrread <= 1'b0;
        end else begin
            done        <= 1'b0;
            writeOrread <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        address   <= startAddress;
                        byteCount <= 8'd0;
                        busy      <= 1'b1;
                        // Out-of-range start skips the RAM entirely.
                        state     <= (startAddress > LastAddress) ? FINISH : FETCH;
                    end
                end
                FETCH: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (dout == '0) begin
                        state <= FINISH;
                    end else begin
                        txData  <= dout;
                        txValid <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (txReady) begin
                        txValid <= 1'b0;
                        if (byteCount != 8'hFF) begin
                            byteCount <= byteCount + 8'd1;
                        end
                        if (address == LastAddress) begin
                            state <= FINISH;
                        end else begin
                            address <= address + AddrWidth'(1);
                            state   <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
